crc16_frame_checker: RTL and testbench
======================================

# crc16_frame_checker

Receive-side companion to the byte-parallel CRC-16 generator. It consumes a framed byte stream whose last two bytes are the transmitted CRC (MSB byte first) and recomputes CRC-16 over the whole frame, one byte per clock. At frame end it reports pass/fail, runt and oversize conditions, the frame length and the received CRC, and it keeps saturating good/bad frame counters. It sits between the byte deframer and the packet buffer that commits or drops frames.

## Interface
- MAX_LEN, 1024: maximum legal frame length in bytes, including the 2 CRC bytes.
- CNT_W, 16: width of the good/bad frame counters.
- clk  in  1  sole clock; all logic updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- data  in  8  frame byte, MSB-first bit order.
- data_valid  in  1  qualifies data/sof/eof; with data_valid low the block holds all state.
- sof  in  1  first byte of a frame (sampled only with data_valid).
- eof  in  1  last byte of a frame (sampled only with data_valid).
- cnt_clr  in  1  synchronous clear of good_cnt/bad_cnt.
- done  out  1  one-cycle pulse; the result outputs are valid.
- crc_ok  out  1  last frame passed (residue 0, no runt, no oversize).
- crc_err  out  1  last frame failed the residue check.
- runt_err  out  1  last frame was shorter than 3 bytes.
- ovs_err  out  1  last frame was longer than MAX_LEN.
- frame_len  out  16  byte count of last frame (saturates at 0xFFFF).
- rx_crc  out  16  last two bytes of last frame, {second-to-last, last}.
- good_cnt  out  CNT_W  saturating count of frames with crc_ok.
- bad_cnt  out  CNT_W  saturating count of completed frames without crc_ok.

## Operation
- CRC: poly 0x1021, init 0xFFFF, no reflection, no final XOR. Eight bit-serial steps are unrolled per byte. A correct frame with its CRC appended MSB byte first leaves residue 0x0000.
- FSM states:
  - IDLE: waits for data_valid&sof. That beat loads crc = step(0xFFFF, data), len = 1, shift = {8'h00, data}, and goes to BODY. If eof is also set, go to REPORT instead.
  - BODY: each valid beat updates crc = step(crc, data), len += 1 (saturating), shift = {shift[7:0], data}. An eof beat goes to REPORT.
  - REPORT: lasts one cycle. It drives done and the result outputs, updates the counters, then returns to IDLE.
- Results, latched at REPORT and held until the next REPORT:
  - runt_err = (len < 3)
  - ovs_err = (len > MAX_LEN)
  - crc_err = !runt_err && (crc != 0)
  - crc_ok = none of the three errors.
- Error priority for counters: any error makes the frame bad; at most one counter increments per frame.
- sof while in BODY: the current frame is silently discarded. No done pulse, no counter update. The beat restarts as a new first byte.
- eof or data beats in IDLE without sof: ignored.
- A valid beat in the REPORT cycle is processed as if seen in IDLE: sof starts a frame, otherwise it is ignored. Back-to-back frames therefore lose nothing.
- Oversize frames keep being consumed until eof; the CRC is still computed; len saturates.
- Counters saturate at all-ones.
- cnt_clr has priority over an increment in the same cycle: the counter becomes 0.

## Timing
- Throughput: one byte per clock, no backpressure.
- Latency: done is asserted in the cycle immediately after the eof beat, as a registered output.
- Counters reflect the frame in the cycle after done.
- Reset values:
  - state IDLE, crc 0xFFFF, len 0, shift 0.
  - done, crc_ok, crc_err, runt_err, ovs_err = 0.
  - frame_len, rx_crc = 0.
  - good_cnt, bad_cnt = 0.
- Reset asserted mid-frame aborts the frame immediately, with no done pulse.
- Gaps (data_valid low) anywhere in a frame are legal and change no state.

## Test plan
- Good frame: bytes 31 32 33 34 35 36 37 38 39 29 B1 (sof on 31, eof on B1), contiguous -> one cycle after eof: done=1, crc_ok=1, crc_err=0, frame_len=11, rx_crc=0x29B1, good_cnt=1.
- Corruption: same frame with the last byte B0 -> done, crc_err=1, crc_ok=0, rx_crc=0x29B0, bad_cnt=1. Same frame with random data_valid gaps -> identical result to the contiguous case.
- Runt: sof+eof on a single byte 0x00 -> done, runt_err=1, crc_err=0, frame_len=1, bad_cnt+1. A 2-byte frame gives the same result with frame_len=2.
- Restart and back-to-back:
  - good frame, with sof reasserted at byte 5 followed by the full good frame -> exactly one done, crc_ok=1, frame_len=11.
  - two good frames with the second sof in the REPORT cycle -> two done pulses, good_cnt=2.
- Oversize with MAX_LEN=16: a 20-byte frame with a correct CRC -> ovs_err=1, crc_err=0, crc_ok=0, frame_len=20, bad_cnt+1.
- Counters and reset:
  - force good_cnt to saturate (CNT_W=4, 16 good frames) -> stays 0xF.
  - cnt_clr coincident with an increment -> 0.
  - rst_n low mid-frame -> all outputs 0; the next good frame gives crc_ok=1.

Source files
------------

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 (poly 0x1021, init 0xFFFF) frame checker, one byte per clock.
// Reports residue/runt/oversize status per frame and keeps saturating good/bad counters.
module crc16_frame_checker #(
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data,
  input  logic             data_valid,
  input  logic             sof,
  input  logic             eof,
  input  logic             cnt_clr,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             runt_err,
  output logic             ovs_err,
  output logic [15:0]      frame_len,
  output logic [15:0]      rx_crc,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam logic [1:0]       IDLE      = 2'd0;
  localparam logic [1:0]       BODY      = 2'd1;
  localparam logic [1:0]       REPORT    = 2'd2;
  localparam logic [31:0]      MAX_LEN_U = 32'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Eight MSB-first serial CRC steps unrolled for one byte.
  function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [7:0] byte_in);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ byte_in[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  logic [1:0]       state_r, state_s;
  logic [15:0]      crc_r, crc_s;
  logic [15:0]      len_r, len_s;
  logic [15:0]      shift_r, shift_s;
  logic             frame_end_s;
  logic             runt_s, ovs_s, crc_bad_s;
  logic             done_r, crc_ok_r, crc_err_r, runt_err_r, ovs_err_r;
  logic [15:0]      frame_len_r, rx_crc_r;
  logic [CNT_W-1:0] good_cnt_r, bad_cnt_r;

  // Next-state datapath: sof restarts from any state, so a REPORT-cycle sof loses nothing.
  always_comb begin
    state_s     = state_r;
    crc_s       = crc_r;
    len_s       = len_r;
    shift_s     = shift_r;
    frame_end_s = 1'b0;
    if (data_valid && sof) begin
      crc_s       = crc_step(16'hFFFF, data);
      len_s       = 16'd1;
      shift_s     = {8'h00, data};
      frame_end_s = eof;
      state_s     = eof ? REPORT : BODY;
    end else if (data_valid && (state_r == BODY)) begin
      crc_s       = crc_step(crc_r, data);
      len_s       = (len_r == 16'hFFFF) ? len_r : (len_r + 16'd1);
      shift_s     = {shift_r[7:0], data};
      frame_end_s = eof;
      state_s     = eof ? REPORT : BODY;
    end else if (state_r == BODY) begin
      state_s = BODY;
    end else begin
      state_s = IDLE;
    end
  end

  // Frame verdict evaluated on the closing beat so it is registered into the REPORT cycle.
  always_comb begin
    runt_s    = (len_s < 16'd3);
    ovs_s     = ({16'd0, len_s} > MAX_LEN_U);
    crc_bad_s = !runt_s && (crc_s != 16'h0000);
  end

  // Frame tracking state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      crc_r   <= 16'hFFFF;
      len_r   <= 16'd0;
      shift_r <= 16'd0;
    end else begin
      state_r <= state_s;
      crc_r   <= crc_s;
      len_r   <= len_s;
      shift_r <= shift_s;
    end
  end

  // Result latch, held until the next frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r      <= 1'b0;
      crc_ok_r    <= 1'b0;
      crc_err_r   <= 1'b0;
      runt_err_r  <= 1'b0;
      ovs_err_r   <= 1'b0;
      frame_len_r <= 16'd0;
      rx_crc_r    <= 16'd0;
    end else begin
      done_r <= frame_end_s;
      if (frame_end_s) begin
        crc_ok_r    <= !(runt_s || ovs_s || crc_bad_s);
        crc_err_r   <= crc_bad_s;
        runt_err_r  <= runt_s;
        ovs_err_r   <= ovs_s;
        frame_len_r <= len_s;
        rx_crc_r    <= shift_s;
      end else begin
        crc_ok_r    <= crc_ok_r;
        crc_err_r   <= crc_err_r;
        runt_err_r  <= runt_err_r;
        ovs_err_r   <= ovs_err_r;
        frame_len_r <= frame_len_r;
        rx_crc_r    <= rx_crc_r;
      end
    end
  end

  // Saturating frame counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_r <= {CNT_W{1'b0}};
      bad_cnt_r  <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      good_cnt_r <= {CNT_W{1'b0}};
      bad_cnt_r  <= {CNT_W{1'b0}};
    end else if (done_r && crc_ok_r) begin
      good_cnt_r <= (good_cnt_r == CNT_MAX) ? good_cnt_r : (good_cnt_r + CNT_ONE);
    end else if (done_r) begin
      bad_cnt_r <= (bad_cnt_r == CNT_MAX) ? bad_cnt_r : (bad_cnt_r + CNT_ONE);
    end else begin
      good_cnt_r <= good_cnt_r;
      bad_cnt_r  <= bad_cnt_r;
    end
  end

  assign done      = done_r;
  assign crc_ok    = crc_ok_r;
  assign crc_err   = crc_err_r;
  assign runt_err  = runt_err_r;
  assign ovs_err   = ovs_err_r;
  assign frame_len = frame_len_r;
  assign rx_crc    = rx_crc_r;
  assign good_cnt  = good_cnt_r;
  assign bad_cnt   = bad_cnt_r;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Randomized self-checking bench for crc16_frame_checker against a frame-level reference model.
module tb_crc16_frame_checker;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_SAT = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       data;
  logic             data_valid, sof, eof, cnt_clr;
  logic             done, crc_ok, crc_err, runt_err, ovs_err;
  logic [15:0]      frame_len, rx_crc;
  logic [CNT_W-1:0] good_cnt, bad_cnt;

  crc16_frame_checker #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .sof(sof), .eof(eof), .cnt_clr(cnt_clr), .done(done), .crc_ok(crc_ok),
    .crc_err(crc_err), .runt_err(runt_err), .ovs_err(ovs_err),
    .frame_len(frame_len), .rx_crc(rx_crc), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int good_m = 0;
  int bad_m = 0;
  logic [7:0]  frm[$];
  logic [36:0] obs_res, exp_res;
  logic [7:0]  obs_cnt, exp_cnt;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // Reference CRC: plain polynomial long division over the frame bits, MSB first.
  function automatic logic [15:0] model_crc();
    logic [15:0] c = 16'hFFFF;
    logic fb;
    foreach (frm[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ frm[i][b];
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic model_frame();
    int n = frm.size();
    logic [15:0] len, rx;
    logic runt, ovs, cerr, ok;
    len  = (n > 65535) ? 16'hFFFF : 16'(n);
    runt = (n < 3);
    ovs  = (n > MAX_LEN);
    cerr = !runt && (model_crc() != 16'h0000);
    ok   = !(runt || ovs || cerr);
    rx   = (n >= 2) ? {frm[n-2], frm[n-1]} : {8'h00, frm[0]};
    if (ok) good_m = (good_m == CNT_SAT) ? CNT_SAT : good_m + 1;
    else    bad_m  = (bad_m == CNT_SAT) ? CNT_SAT : bad_m + 1;
    exp_res = {1'b1, ok, cerr, runt, ovs, len, rx};
    exp_cnt = {4'(good_m), 4'(bad_m)};
  endtask

  task automatic gen_good(input int n);
    logic [15:0] c;
    frm.delete();
    for (int i = 0; i < n - 2; i++) frm.push_back(8'($urandom));
    c = model_crc();
    frm.push_back(c[15:8]);
    frm.push_back(c[7:0]);
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic e);
    data = d; sof = s; eof = e; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  task automatic drive_frame(input int gap_pct);
    for (int i = 0; i < frm.size(); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        data = 8'($urandom); sof = 1'($urandom); eof = 1'($urandom);
        @(posedge clk); #1;
      end
      beat(frm[i], i == 0, i == frm.size() - 1);
    end
  endtask

  task automatic capture();
    obs_res = {done, crc_ok, crc_err, runt_err, ovs_err, frame_len, rx_crc};
    @(posedge clk); #1;
    obs_cnt = {good_cnt, bad_cnt};
  endtask

  task automatic send_frame(input int gap_pct);
    drive_frame(gap_pct);
    capture();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data = 8'h00; data_valid = 1'b0; sof = 1'b0; eof = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs_res = {done, crc_ok, crc_err, runt_err, ovs_err, frame_len, rx_crc};
    obs_cnt = {good_cnt, bad_cnt};
    checks++; if (obs_res !== 37'd0) begin errors++; $display("FAIL reset_results: got %h expected 0", obs_res); end
    checks++; if (obs_cnt !== 8'd0) begin errors++; $display("FAIL reset_counters: got %h expected 0", obs_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    logic [36:0] k;
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    model_frame();
    send_frame(0);
    k = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd11, 16'h29B1};
    checks++; if (obs_res !== k) begin errors++; $display("FAIL good_frame: got %h expected %h", obs_res, k); end
    checks++; if (obs_cnt !== 8'h10) begin errors++; $display("FAIL good_frame_cnt: got %h expected 10", obs_cnt); end
  endtask

  task automatic test_corrupt();
    logic [36:0] k;
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB0};
    model_frame();
    send_frame(0);
    k = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd11, 16'h29B0};
    checks++; if (obs_res !== k) begin errors++; $display("FAIL corrupt: got %h expected %h", obs_res, k); end
    checks++; if (obs_cnt !== 8'h11) begin errors++; $display("FAIL corrupt_cnt: got %h expected 11", obs_cnt); end
    frm[10] = 8'hB1;
    model_frame();
    send_frame(40);
    checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL gapped_good: got %h expected %h", obs_res, exp_res); end
    checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL gapped_good_cnt: got %h expected %h", obs_cnt, exp_cnt); end
  endtask

  task automatic test_runt();
    frm = '{8'h00};
    model_frame();
    send_frame(0);
    checks++; if (obs_res !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 16'h0000}) begin
      errors++; $display("FAIL runt1: got %h expected %h", obs_res, {1'b1, 4'b0010, 16'd1, 16'h0000}); end
    checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL runt1_cnt: got %h expected %h", obs_cnt, exp_cnt); end
    frm = '{8'($urandom), 8'($urandom)};
    model_frame();
    send_frame(20);
    checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL runt2: got %h expected %h", obs_res, exp_res); end
    checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL runt2_cnt: got %h expected %h", obs_cnt, exp_cnt); end
  endtask

  task automatic test_restart();
    int d0;
    gen_good(11);
    model_frame();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) beat(frm[i], i == 0, 1'b0);
    send_frame(0);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL restart_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL restart: got %h expected %h", obs_res, exp_res); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int g0 = good_m;
    gen_good(7);
    model_frame();
    drive_frame(0);
    gen_good(9);
    model_frame();
    drive_frame(0);
    capture();
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done: got %0d expected 2", done_cnt - d0); end
    checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL b2b: got %h expected %h", obs_res, exp_res); end
    checks++; if (obs_cnt !== exp_cnt || good_m - g0 != 2) begin errors++; $display("FAIL b2b_cnt: got %h expected %h", obs_cnt, exp_cnt); end
  endtask

  task automatic test_oversize();
    logic [36:0] k;
    gen_good(20);
    model_frame();
    send_frame(10);
    k = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, frm[18], frm[19]};
    checks++; if (obs_res !== k) begin errors++; $display("FAIL oversize: got %h expected %h", obs_res, k); end
    checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL oversize_cnt: got %h expected %h", obs_cnt, exp_cnt); end
    for (int n = MAX_LEN; n <= MAX_LEN + 1; n++) begin
      gen_good(n);
      model_frame();
      send_frame(0);
      checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL len_boundary_%0d: got %h expected %h", n, obs_res, exp_res); end
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, MAX_LEN + 6);
      if (n >= 3) gen_good(n);
      else begin frm.delete(); for (int i = 0; i < n; i++) frm.push_back(8'($urandom)); end
      if ($urandom_range(2) == 0) frm[$urandom_range(n - 1)] ^= 8'($urandom_range(1, 255));
      model_frame();
      send_frame(25);
      checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL random_%0d: got %h expected %h", t, obs_res, exp_res); end
      checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL random_cnt_%0d: got %h expected %h", t, obs_cnt, exp_cnt); end
    end
  endtask

  task automatic test_saturate();
    repeat (17) begin
      gen_good(6);
      model_frame();
      send_frame(0);
    end
    checks++; if (obs_cnt !== exp_cnt || obs_cnt[7:4] !== 4'hF) begin
      errors++; $display("FAIL good_saturate: got %h expected %h", obs_cnt, exp_cnt); end
  endtask

  task automatic test_cnt_clr();
    gen_good(6);
    model_frame();
    drive_frame(0);
    cnt_clr = 1'b1;
    capture();
    cnt_clr = 1'b0;
    good_m = 0; bad_m = 0;
    checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL clr_frame: got %h expected %h", obs_res, exp_res); end
    checks++; if (obs_cnt !== 8'h00) begin errors++; $display("FAIL cnt_clr: got %h expected 00", obs_cnt); end
  endtask

  task automatic test_reset_mid();
    gen_good(10);
    for (int i = 0; i < 5; i++) beat(frm[i], i == 0, 1'b0);
    rst_n = 1'b0;
    #1;
    obs_res = {done, crc_ok, crc_err, runt_err, ovs_err, frame_len, rx_crc};
    obs_cnt = {good_cnt, bad_cnt};
    good_m = 0; bad_m = 0;
    checks++; if (obs_res !== 37'd0 || obs_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_mid: got %h/%h expected 0/0", obs_res, obs_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 5; i < 10; i++) beat(frm[i], 1'b0, i == 9);
    obs_res = {done, crc_ok, crc_err, runt_err, ovs_err, frame_len, rx_crc};
    checks++; if (obs_res[36] !== 1'b0) begin errors++; $display("FAIL reset_abort: got done=%b expected 0", obs_res[36]); end
    gen_good(11);
    model_frame();
    send_frame(0);
    checks++; if (obs_res !== exp_res) begin errors++; $display("FAIL after_reset: got %h expected %h", obs_res, exp_res); end
    checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL after_reset_cnt: got %h expected %h", obs_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_corrupt();
    test_runt();
    test_restart();
    test_back_to_back();
    test_oversize();
    test_random();
    test_saturate();
    test_cnt_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
